// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing the fifo write port; one bubble cycle per grant, bursts of up to MAX_BURST beats.
// Outputs are combinational from the held grant, and requesters are stalled (req_ready=0) while fifo_full is high.
module fifo_wr_arb #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic                          busy,
    output logic [2:0]                    grant_id
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t        state_q;
    logic [IW-1:0] cur_q;
    logic [IW-1:0] last_q;
    logic [3:0]    beat_q;
    logic [2:0]    gid_q;

    logic [IW-1:0] pick;
    logic          pick_vld;
    int            idx;

    // Scan starts one past the last grant and wraps modulo NUM_REQ.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (!pick_vld && req_valid[idx[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick     = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        if (state_q == GRANT) begin
            fifo_wr_data = req_data[int'(cur_q)*DATA_WIDTH +: DATA_WIDTH];
            if (rst && !fifo_full) begin
                req_ready[cur_q] = 1'b1;
                fifo_wr_en       = req_valid[cur_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            last_q  <= LAST_RST;
            beat_q  <= '0;
            gid_q   <= 3'(NUM_REQ - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        state_q <= GRANT;
                        cur_q   <= pick;
                        gid_q   <= 3'(pick);
                        beat_q  <= '0;
                    end
                end
                GRANT: begin
                    // A full fifo freezes the grant entirely, including the final beat.
                    if (!fifo_full) begin
                        if (req_valid[cur_q]) begin
                            beat_q <= beat_q + 4'd1;
                            if (beat_q + 4'd1 == 4'(MAX_BURST)) begin
                                state_q <= IDLE;
                                last_q  <= cur_q;
                            end
                        end else begin
                            state_q <= IDLE;
                            last_q  <= cur_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q == GRANT);
    assign grant_id = gid_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fifo_wr_arb;
    localparam int N  = 3;
    localparam int DW = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wr_data;
    logic            busy;
    logic [2:0]      grant_id;
    logic [DW-1:0]   src_data [N];

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = src_data[i];
    end

    fifo_wr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data), .busy(busy), .grant_id(grant_id)
    );

    // Second instance: two requesters, single-beat bursts.
    logic [1:0]  v2;
    logic [15:0] d2;
    logic [1:0]  rdy2;
    logic        full2;
    logic        en2;
    logic [7:0]  wd2;
    logic        busy2;
    logic [2:0]  gid2;

    fifo_wr_arb #(.NUM_REQ(2), .DATA_WIDTH(8), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_data(d2),
        .req_ready(rdy2), .fifo_full(full2), .fifo_wr_en(en2),
        .fifo_wr_data(wd2), .busy(busy2), .grant_id(gid2)
    );

    int vectors = 0;
    int errors  = 0;

    // Model: owner of the write port (-1 when nobody holds it), beats it has written, last owner.
    int m_owner = -1;
    int m_beats = 0;
    int m_last  = N - 1;
    int m_gid   = N - 1;

    logic [15:0] exp_v;
    logic [15:0] got_v;
    logic [N-1:0] hs;

    function automatic logic [15:0] pk(input logic b, input logic [2:0] g, input logic [2:0] r,
                                       input logic e, input logic [7:0] d);
        return {b, g, r, e, d};
    endfunction

    task automatic settle();
        logic [N-1:0] er;
        logic         ee;
        logic [7:0]   ed;
        @(negedge clk);
        er = '0;
        ee = 1'b0;
        ed = '0;
        if (m_owner >= 0) begin
            ed = src_data[m_owner];
            if (rst && !fifo_full) begin
                er[m_owner] = 1'b1;
                ee          = req_valid[m_owner];
            end
        end
        exp_v = pk(m_owner >= 0, 3'(m_gid), er, ee, ed);
        got_v = {busy, grant_id, req_ready, fifo_wr_en, fifo_wr_data};
        hs    = req_valid & req_ready;
    endtask

    task automatic advance();
        int p;
        @(posedge clk);
        if (!rst) begin
            m_owner = -1; m_beats = 0; m_last = N - 1; m_gid = N - 1;
        end else if (m_owner < 0) begin
            p = -1;
            for (int k = 1; k <= N; k++)
                if (p < 0 && req_valid[(m_last + k) % N]) p = (m_last + k) % N;
            if (p >= 0) begin
                m_owner = p; m_gid = p; m_beats = 0;
            end
        end else if (!fifo_full) begin
            if (req_valid[m_owner]) m_beats++;
            if (!req_valid[m_owner] || m_beats == MB) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
        #1;
        for (int i = 0; i < N; i++) if (hs[i]) src_data[i] = src_data[i] + 8'd1;
    endtask

    task automatic apply_reset();
        rst = 1'b0; req_valid = '0; fifo_full = 1'b0; v2 = '0;
        settle();
        advance();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 3'b111; fifo_full = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            vectors++;
            if (got_v !== pk(1'b0, 3'd2, 3'b000, 1'b0, 8'h00)) begin
                errors++;
                $display("FAIL reset cycle %0d: got %h expected %h", c, got_v, pk(1'b0, 3'd2, 3'b000, 1'b0, 8'h00));
            end
            advance();
        end
        rst = 1'b1;
    endtask

    task automatic test_stream();
        logic [7:0] eb;
        logic       pat;
        apply_reset();
        src_data[0] = 8'hA0; src_data[1] = 8'hB0; src_data[2] = 8'hC0;
        req_valid = 3'b111;
        for (int c = 0; c < 15; c++) begin
            settle();
            vectors++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL stream_model cycle %0d: got %h expected %h", c, got_v, exp_v);
            end
            pat = (c % 5) != 0;
            eb  = 8'hA0 + 8'(16 * (c / 5) + (c % 5) - 1);
            vectors++;
            if (fifo_wr_en !== pat || (pat && (fifo_wr_data !== eb || grant_id !== 3'(c / 5)))) begin
                errors++;
                $display("FAIL stream_pattern cycle %0d: got en=%b data=%h gid=%0d expected en=%b data=%h gid=%0d",
                         c, fifo_wr_en, fifo_wr_data, grant_id, pat, eb, c / 5);
            end
            advance();
        end
    endtask

    task automatic test_single();
        logic [15:0] tab [7];
        apply_reset();
        src_data[0] = 8'h10; src_data[2] = 8'h5A;
        req_valid = 3'b100;
        tab = '{pk(0, 2, 3'b000, 0, 8'h00), pk(1, 2, 3'b100, 1, 8'h5A), pk(1, 2, 3'b100, 1, 8'h5B),
                pk(1, 2, 3'b100, 0, 8'h5C), pk(0, 2, 3'b000, 0, 8'h00), pk(1, 0, 3'b001, 1, 8'h10),
                pk(1, 0, 3'b001, 1, 8'h11)};
        for (int c = 0; c < 7; c++) begin
            settle();
            vectors++;
            if (got_v !== tab[c] || got_v !== exp_v) begin
                errors++;
                $display("FAIL single_req2 cycle %0d: got %h expected %h (model %h)", c, got_v, tab[c], exp_v);
            end
            advance();
            if (src_data[2] == 8'h5C) req_valid[2] = 1'b0;
            if (c == 3) req_valid = 3'b011;
        end
    endtask

    task automatic test_full_stall();
        logic [15:0] tab [9];
        int nw;
        apply_reset();
        src_data[1] = 8'hD0;
        req_valid = 3'b010;
        nw = 0;
        tab = '{pk(0, 2, 3'b000, 0, 8'h00), pk(1, 1, 3'b010, 1, 8'hD0), pk(1, 1, 3'b000, 0, 8'hD1),
                pk(1, 1, 3'b000, 0, 8'hD1), pk(1, 1, 3'b000, 0, 8'hD1), pk(1, 1, 3'b010, 1, 8'hD1),
                pk(1, 1, 3'b010, 1, 8'hD2), pk(1, 1, 3'b010, 1, 8'hD3), pk(0, 1, 3'b000, 0, 8'h00)};
        for (int c = 0; c < 9; c++) begin
            fifo_full = (c >= 2 && c <= 4);
            settle();
            if (fifo_wr_en === 1'b1) nw++;
            vectors++;
            if (got_v !== tab[c] || got_v !== exp_v) begin
                errors++;
                $display("FAIL full_stall cycle %0d: got %h expected %h (model %h)", c, got_v, tab[c], exp_v);
            end
            advance();
        end
        fifo_full = 1'b0;
        vectors++;
        if (nw !== MB) begin
            errors++;
            $display("FAIL full_stall_beats: got %0d writes expected %0d", nw, MB);
        end
    endtask

    task automatic test_reset_midburst();
        logic [15:0] tab [7];
        apply_reset();
        src_data[0] = 8'h30; src_data[2] = 8'hE0;
        req_valid = 3'b100;
        tab = '{pk(0, 2, 3'b000, 0, 8'h00), pk(1, 2, 3'b100, 1, 8'hE0), pk(1, 2, 3'b100, 1, 8'hE1),
                pk(1, 2, 3'b000, 0, 8'hE2), pk(0, 2, 3'b000, 0, 8'h00), pk(1, 0, 3'b001, 1, 8'h30),
                pk(1, 0, 3'b001, 1, 8'h31)};
        for (int c = 0; c < 7; c++) begin
            rst = (c != 3);
            if (c >= 4) req_valid = 3'b111;
            settle();
            vectors++;
            if (got_v !== tab[c] || got_v !== exp_v) begin
                errors++;
                $display("FAIL reset_midburst cycle %0d: got %h expected %h (model %h)", c, got_v, tab[c], exp_v);
            end
            advance();
        end
        rst = 1'b1;
    endtask

    task automatic test_full_last_beat();
        logic [15:0] tab [8];
        apply_reset();
        src_data[0] = 8'hF0;
        req_valid = 3'b001;
        tab = '{pk(0, 2, 3'b000, 0, 8'h00), pk(1, 0, 3'b001, 1, 8'hF0), pk(1, 0, 3'b001, 1, 8'hF1),
                pk(1, 0, 3'b001, 1, 8'hF2), pk(1, 0, 3'b000, 0, 8'hF3), pk(1, 0, 3'b001, 1, 8'hF3),
                pk(0, 0, 3'b000, 0, 8'h00), pk(1, 0, 3'b001, 1, 8'hF4)};
        for (int c = 0; c < 8; c++) begin
            fifo_full = (c == 4);
            settle();
            vectors++;
            if (got_v !== tab[c] || got_v !== exp_v) begin
                errors++;
                $display("FAIL full_last_beat cycle %0d: got %h expected %h (model %h)", c, got_v, tab[c], exp_v);
            end
            advance();
        end
        fifo_full = 1'b0;
    endtask

    task automatic test_alternate();
        logic [14:0] ev;
        logic [14:0] gv;
        logic [2:0]  g;
        logic        e;
        apply_reset();
        v2 = 2'b11;
        for (int c = 0; c < 10; c++) begin
            settle();
            e  = (c % 2) == 1;
            g  = (c == 0) ? 3'd1 : 3'(((c - 1) / 2) % 2);
            ev = {e, g, e ? (2'b01 << g) : 2'b00, e, e ? ((g == 0) ? 8'h11 : 8'h22) : 8'h00};
            gv = {busy2, gid2, rdy2, en2, wd2};
            vectors++;
            if (gv !== ev) begin
                errors++;
                $display("FAIL alternate_burst1 cycle %0d: got %h expected %h", c, gv, ev);
            end
            advance();
        end
        v2 = '0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < N; i++) src_data[i] = 8'($urandom);
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) req_valid[i] = ($urandom_range(3) != 0);
            fifo_full = ($urandom_range(4) == 0);
            rst       = ($urandom_range(60) != 0);
            settle();
            vectors++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random cycle %0d: got %h expected %h", c, got_v, exp_v);
            end
            advance();
        end
        rst = 1'b1;
        fifo_full = 1'b0;
    endtask

    initial begin
        rst = 1'b0; req_valid = '0; fifo_full = 1'b0;
        v2 = '0; d2 = 16'h2211; full2 = 1'b0;
        for (int i = 0; i < N; i++) src_data[i] = '0;
        test_reset();
        test_stream();
        test_single();
        test_full_stall();
        test_reset_midburst();
        test_full_last_beat();
        test_alternate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        if (errors == 0) $display("PASS");
        else $display("FAIL");
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
- Round-robin arbiter that shares the single write port of the team's `fifo` block between NUM_REQ valid/ready requesters (GPIO/input-stream sources).
- Grants one requester at a time and holds the grant for a burst of up to MAX_BURST beats.
- Drives `wr_en`/`wr_data` and back-pressures requesters from the FIFO `full` flag.
- Sits between the input sources in `top` and the `fifo` write side, in the `wr_clk` domain.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_WIDTH, 8, data width; matches the `fifo` DATA_WIDTH.
- MAX_BURST, 4, maximum consecutive beats per grant (1..15).

Ports:
- clk  input  1  clock; same clock as the fifo `wr_clk`.
- rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- req_valid  input  NUM_REQ  per-requester data valid.
- req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  per-requester accept; a beat transfers when valid and ready are both 1.
- fifo_full  input  1  `full` from the fifo.
- fifo_wr_en  output  1  to fifo `wr_en`.
- fifo_wr_data  output  DATA_WIDTH  to fifo `wr_data`.
- busy  output  1  1 while in GRANT.
- grant_id  output  3  index of the current or last granted requester.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE, beat_cnt=0, last_grant=NUM_REQ-1 (so requester 0 has first priority).
  - Outputs: req_ready=0, fifo_wr_en=0, fifo_wr_data=0, busy=0, grant_id=NUM_REQ-1.
  - Reset asserted mid-burst aborts the burst immediately. No write occurs in the reset cycle; fifo_wr_en is gated by rst.
- IDLE state:
  - All req_ready=0, fifo_wr_en=0.
  - If any req_valid=1: pick the first asserted index scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - On the next edge: latch it as cur, set grant_id=cur, beat_cnt=0, state=GRANT.
  - Arbitration costs exactly one bubble cycle per grant.
- GRANT state (combinational outputs):
  - req_ready[cur] = ~fifo_full; all other req_ready bits = 0.
  - fifo_wr_en = req_valid[cur] & ~fifo_full.
  - fifo_wr_data = req_data slice of cur, driven in every GRANT cycle; 0 in IDLE.
  - Transfer cycle (fifo_wr_en=1): beat_cnt increments. If beat_cnt+1 == MAX_BURST, go to IDLE and set last_grant=cur.
  - req_valid[cur]=0 while fifo_full=0: go to IDLE, last_grant=cur. A grant with zero beats still rotates priority.
  - fifo_full=1: hold the grant, no transfer, beat_cnt unchanged, regardless of req_valid[cur]. No timeout.
- Burst length and ordering:
  - A burst never exceeds MAX_BURST beats.
  - Back-to-back grants to different requesters are separated by one IDLE cycle.
  - Fairness: a requester that keeps valid high is served within NUM_REQ grants.
- Simultaneous events:
  - fifo_full rising in the same cycle as the last burst beat: fifo_full wins. No transfer, stay in GRANT.
  - Non-granted requesters asserting valid during GRANT are ignored until the next IDLE.
- Widths and index:
  - beat_cnt is 4 bits.
  - grant_id is zero-extended from clog2(NUM_REQ) bits.
  - Requester index wrap-around is modulo NUM_REQ, not a power-of-two mask.
- No data is buffered inside the block. The FIFO full/empty policy is owned by `fifo`; this block only honours `full`.

Test Plan:
- Reset then req_valid=3'b111, fifo_full=0, each requester streaming:
  - req0 writes 4 beats (e.g. A0..A3), 1 idle cycle, req1 writes 4 beats, idle, then req2.
  - fifo_wr_en pattern 0,1,1,1,1,0,1,1,1,1,0,...
- Only req2 valid, data 8'h5A, 8'h5B:
  - IDLE one cycle, grant_id=2, two writes, req_valid drops, back to IDLE.
  - Next grant scan starts at req0.
- fifo_full=1 asserted for 3 cycles on beat 2 of a burst to req1:
  - req_ready[1]=0 and fifo_wr_en=0 for exactly those 3 cycles; busy stays 1.
  - After full deasserts, beats 2..4 complete; total 4 beats written, no duplicates or drops.
- req0 valid continuously with MAX_BURST=1, req1 valid:
  - Grants alternate 0,1,0,1.
  - fifo_wr_data alternates between the two sources with one bubble between beats.
- rst=0 asserted on beat 3 of a burst:
  - Next cycle all outputs are at reset values.
  - After release, req0 has first priority even though req2 was previously granted.
- fifo_full and the final burst beat in the same cycle:
  - No write occurs, state stays GRANT.
  - The beat is written once full clears, then the block returns to IDLE.
